// File: rtl/hazard_pkg.sv
// Shared scoreboard slot type and readiness helper for the pipeline hazard controller.
// Slot dst is stored at HZ_DST_W bits, so REG_AW may be at most HZ_DST_W.
package hazard_pkg;

    localparam int unsigned HZ_DST_W = 8;

    typedef struct packed {
        logic                valid;
        logic                we;
        logic [HZ_DST_W-1:0] dst;
        logic                load;
    } hz_slot_t;

    localparam logic [HZ_DST_W-1:0] REG_ZERO = '0;

    // A load's value only reaches stg_data_i from load_rdy_slot onward.
    function automatic logic is_ready(input hz_slot_t slot, input int unsigned idx,
                                      input int unsigned load_rdy_slot);
        return !slot.load || (idx >= load_rdy_slot);
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Per-source scoreboard lookup: youngest matching slot, its index, and readiness.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_STG       = 3,
    parameter int unsigned REG_AW        = 5,
    parameter int unsigned LOAD_RDY_SLOT = 1,
    parameter int unsigned IDX_W         = (NUM_STG > 1) ? $clog2(NUM_STG) : 1
) (
    input  hz_slot_t          slots [NUM_STG],
    input  logic              src_use,
    input  logic [REG_AW-1:0] src_addr,
    output logic              fwd_en,
    output logic [IDX_W-1:0]  sel,
    output logic              not_ready
);

    logic                found;
    logic                ready;
    logic [HZ_DST_W-1:0] addr_ext;

    assign addr_ext = HZ_DST_W'(src_addr);

    always_comb begin
        found = 1'b0;
        ready = 1'b0;
        sel   = '0;
        for (int unsigned s = 0; s < NUM_STG; s++) begin
            if (!found && src_use && addr_ext != REG_ZERO &&
                slots[s].valid && slots[s].we && slots[s].dst == addr_ext) begin
                found = 1'b1;
                sel   = IDX_W'(s);
                ready = is_ready(slots[s], s, LOAD_RDY_SLOT);
            end
        end
        fwd_en    = found & ready;
        not_ready = found & ~ready;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based hazard/forwarding controller: forwarding selects, load-use stall, flush, freeze.
// Optional HAZARD_PERF_EN adds stall and forward performance counters.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_SRC       = 2,
    parameter int unsigned NUM_STG       = 3,
    parameter int unsigned REG_AW        = 5,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned LOAD_RDY_SLOT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      iss_valid_i,
    input  logic                      iss_we_i,
    input  logic [REG_AW-1:0]         iss_dst_i,
    input  logic                      iss_load_i,
    input  logic [NUM_SRC-1:0]        src_use_i,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr_i,
    input  logic [NUM_STG*DATA_W-1:0] stg_data_i,
    input  logic                      flush_i,
    input  logic                      ext_stall_i,
    output logic                      stall_o,
    output logic [NUM_SRC-1:0]        fwd_en_o,
    output logic [NUM_SRC*DATA_W-1:0] fwd_data_o
`ifdef HAZARD_PERF_EN
   ,output logic [31:0]               perf_stall_cnt_o,
    output logic [31:0]               perf_fwd_cnt_o
`endif
);

    localparam int unsigned IDX_W = (NUM_STG > 1) ? $clog2(NUM_STG) : 1;

    hz_slot_t           slots [NUM_STG];
    hz_slot_t           issue_slot;
    logic [IDX_W-1:0]   sel [NUM_SRC];
    logic [NUM_SRC-1:0] not_ready;
    logic               hazard_stall;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        hazard_src_match #(
            .NUM_STG       (NUM_STG),
            .REG_AW        (REG_AW),
            .LOAD_RDY_SLOT (LOAD_RDY_SLOT),
            .IDX_W         (IDX_W)
        ) u_match (
            .slots     (slots),
            .src_use   (src_use_i[k]),
            .src_addr  (src_addr_i[k*REG_AW +: REG_AW]),
            .fwd_en    (fwd_en_o[k]),
            .sel       (sel[k]),
            .not_ready (not_ready[k])
        );
    end

    assign hazard_stall = |not_ready;
    assign stall_o      = hazard_stall & ~flush_i;

    always_comb begin
        fwd_data_o = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (fwd_en_o[k]) begin
                fwd_data_o[k*DATA_W +: DATA_W] = stg_data_i[int'(sel[k])*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        issue_slot       = '0;
        issue_slot.valid = iss_valid_i;
        issue_slot.we    = iss_we_i;
        issue_slot.dst   = HZ_DST_W'(iss_dst_i);
        issue_slot.load  = iss_load_i;
    end

    // Flush and hazard both bubble slot0 while older slots keep draining toward W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < NUM_STG; s++) begin
                slots[s] <= '0;
            end
        end else if (!ext_stall_i) begin
            slots[0] <= (flush_i || hazard_stall) ? hz_slot_t'('0) : issue_slot;
            for (int unsigned s = 1; s < NUM_STG; s++) begin
                slots[s] <= slots[s-1];
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt_o <= '0;
            perf_fwd_cnt_o   <= '0;
        end else if (!ext_stall_i) begin
            if (stall_o) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            end
            perf_fwd_cnt_o <= perf_fwd_cnt_o + 32'($countones(fwd_en_o));
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl with default parameters.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iss_valid_i, iss_we_i, iss_load_i;
    logic [4:0]  iss_dst_i;
    logic [1:0]  src_use_i;
    logic [9:0]  src_addr_i;
    logic [95:0] stg_data_i;
    logic        flush_i, ext_stall_i;
    logic        stall_o;
    logic [1:0]  fwd_en_o;
    logic [63:0] fwd_data_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .NUM_SRC       (2),
        .NUM_STG       (3),
        .REG_AW        (5),
        .DATA_W        (32),
        .LOAD_RDY_SLOT (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .iss_valid_i (iss_valid_i),
        .iss_we_i    (iss_we_i),
        .iss_dst_i   (iss_dst_i),
        .iss_load_i  (iss_load_i),
        .src_use_i   (src_use_i),
        .src_addr_i  (src_addr_i),
        .stg_data_i  (stg_data_i),
        .flush_i     (flush_i),
        .ext_stall_i (ext_stall_i),
        .stall_o     (stall_o),
        .fwd_en_o    (fwd_en_o),
        .fwd_data_o  (fwd_data_o)
    );

    typedef struct {
        logic        iv, we, ld;
        logic [4:0]  dst;
        logic [1:0]  use_;
        logic [4:0]  a0, a1;
        logic [31:0] s0, s1, s2;
        logic        fl, ex;
        logic        e_st;
        logic [1:0]  e_en;
        logic [31:0] e_f0, e_f1;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(input logic iv, we, input logic [4:0] dst, input logic ld,
                                input logic [1:0] use_, input logic [4:0] a0, a1,
                                input logic [31:0] s0, s1, s2, input logic fl, ex,
                                input logic e_st, input logic [1:0] e_en,
                                input logic [31:0] e_f0, e_f1);
        vec_t v;
        v.iv = iv; v.we = we; v.dst = dst; v.ld = ld;
        v.use_ = use_; v.a0 = a0; v.a1 = a1;
        v.s0 = s0; v.s1 = s1; v.s2 = s2; v.fl = fl; v.ex = ex;
        v.e_st = e_st; v.e_en = e_en; v.e_f0 = e_f0; v.e_f1 = e_f1;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", name, idx, act, exp_v);
        end
    endtask

    task automatic apply(input vec_t v);
        iss_valid_i = v.iv; iss_we_i = v.we; iss_dst_i = v.dst; iss_load_i = v.ld;
        src_use_i   = v.use_;
        src_addr_i  = {v.a1, v.a0};
        stg_data_i  = {v.s2, v.s1, v.s0};
        flush_i     = v.fl;
        ext_stall_i = v.ex;
    endtask

    task automatic check_outs(input int idx, input logic e_st, input logic [1:0] e_en,
                              input logic [31:0] e_f0, e_f1);
        chk("stall", idx, 32'(stall_o), 32'(e_st));
        chk("fwd_en", idx, 32'(fwd_en_o), 32'(e_en));
        chk("fwd_data0", idx, fwd_data_o[31:0], e_f0);
        chk("fwd_data1", idx, fwd_data_o[63:32], e_f1);
    endtask

    initial begin
        // Scoreboard comments show [slot0,slot1,slot2] after each edge; L = load, b = bubble.
        vecs[0]  = mk(0,0,0,0, 2'b11,8,9, 0,0,0, 0,0, 0,2'b00,0,0);                    // reset state
        vecs[1]  = mk(1,1,8,0, 2'b00,0,0, 0,0,0, 0,0, 0,2'b00,0,0);                    // [8,b,b]
        vecs[2]  = mk(1,1,9,1, 2'b01,8,0, 32'h1234,0,0, 0,0, 0,2'b01,32'h1234,0);      // [L9,8,b]
        vecs[3]  = mk(1,1,3,0, 2'b10,0,9, 0,0,0, 0,0, 1,2'b00,0,0);                    // [b,L9,8]
        vecs[4]  = mk(0,0,0,0, 2'b11,8,9, 0,32'hCAFE,5, 0,0, 0,2'b11,5,32'hCAFE);      // [b,b,L9]
        vecs[5]  = mk(1,1,5,0, 2'b00,0,0, 0,0,0, 0,0, 0,2'b00,0,0);                    // [5,b,b]
        vecs[6]  = mk(0,0,0,0, 2'b00,0,0, 0,0,0, 0,0, 0,2'b00,0,0);                    // [b,5,b]
        vecs[7]  = mk(1,1,5,0, 2'b00,0,0, 0,0,0, 0,0, 0,2'b00,0,0);                    // [5,b,5]
        vecs[8]  = mk(1,1,5,1, 2'b01,5,0, 1,0,2, 0,0, 0,2'b01,1,0);                    // [L5,5,b]
        vecs[9]  = mk(0,0,0,0, 2'b01,5,0, 1,2,0, 0,0, 1,2'b00,0,0);                    // [b,L5,5]
        vecs[10] = mk(0,0,0,0, 2'b01,5,0, 0,32'h77,2, 0,0, 0,2'b01,32'h77,0);          // [b,b,L5]
        vecs[11] = mk(1,1,0,0, 2'b00,0,0, 0,0,0, 0,0, 0,2'b00,0,0);                    // [Z,b,b]
        vecs[12] = mk(0,0,0,0, 2'b11,0,0, 9,9,9, 0,0, 0,2'b00,0,0);                    // [b,Z,b]
        vecs[13] = mk(1,1,9,1, 2'b00,0,0, 0,0,0, 0,0, 0,2'b00,0,0);                    // [L9,b,Z]
        vecs[14] = mk(1,1,4,0, 2'b01,9,0, 0,0,0, 1,0, 0,2'b00,0,0);                    // [b,L9,b]
        vecs[15] = mk(0,0,0,0, 2'b11,4,9, 0,32'hCAFE,0, 0,0, 0,2'b10,0,32'hCAFE);      // [b,b,L9]
        vecs[16] = mk(1,1,7,0, 2'b00,0,0, 0,0,0, 0,0, 0,2'b00,0,0);                    // [7,b,b]
        vecs[17] = mk(1,1,6,0, 2'b01,7,0, 32'hAA,0,0, 0,1, 0,2'b01,32'hAA,0);          // frozen
        vecs[18] = mk(1,1,6,0, 2'b01,7,0, 32'hAA,0,0, 1,1, 0,2'b01,32'hAA,0);          // frozen
        vecs[19] = mk(1,1,6,1, 2'b11,7,6, 32'hBB,0,0, 0,1, 0,2'b01,32'hBB,0);          // frozen
        vecs[20] = mk(0,0,0,0, 2'b11,7,9, 32'hBB,0,0, 0,0, 0,2'b01,32'hBB,0);          // [b,7,b]

        apply(mk(0,0,0,0, 2'b00,0,0, 0,0,0, 0,0, 0,2'b00,0,0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #2;
            check_outs(i, vecs[i].e_st, vecs[i].e_en, vecs[i].e_f0, vecs[i].e_f1);
        end

        // Load into [L9,b,7], then hit it while also forwarding 7 from slot2.
        @(negedge clk);
        apply(mk(1,1,9,1, 2'b00,0,0, 0,0,0, 0,0, 0,2'b00,0,0));
        @(negedge clk);
        apply(mk(0,0,0,0, 2'b11,7,9, 0,0,32'hD0, 0,0, 0,2'b00,0,0));
        #2;
        check_outs(100, 1'b1, 2'b01, 32'hD0, 32'h0);

        // Asynchronous reset mid-cycle must clear everything before the next edge.
        #1;
        rst = 1'b1;
        #1;
        check_outs(101, 1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check_outs(102, 1'b0, 2'b00, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard/forwarding controller for the in-order pipeline. It replaces the fixed E/M/W compare logic with an internal scoreboard of in-flight destination registers, one slot per post-decode stage. It produces per-source forwarding selects and data, a load-use stall, and honours branch flush and external freeze. It sits beside Decode and drives the forwarding muxes in Execute plus the PC/Decode stall.

Parameters:
NUM_SRC, 2, number of decode-stage source operands checked
NUM_STG, 3, number of tracked stages after decode (slot 0 = E, slot NUM_STG-1 = W)
REG_AW, 5, register address width
DATA_W, 32, forwarded data width
LOAD_RDY_SLOT, 1, first slot index at which a load's result is valid on stg_data_i

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
iss_valid_i  in  1  decode instruction advances to E this cycle (if not stalled)
iss_we_i  in  1  issuing instruction writes a register
iss_dst_i  in  REG_AW  issuing destination register
iss_load_i  in  1  issuing instruction is a load
src_use_i  in  NUM_SRC  per-source "operand is read"
src_addr_i  in  NUM_SRC*REG_AW  per-source register address, packed
stg_data_i  in  NUM_STG*DATA_W  result value of each stage (alu_out_e, alu_out_m, result_w, ...)
flush_i  in  1  squash D and E (taken branch/jump resolved)
ext_stall_i  in  1  freeze whole pipeline (memory wait)
stall_o  out  1  hold PC and D, insert bubble into E
fwd_en_o  out  NUM_SRC  source takes fwd_data_o instead of register file
fwd_data_o  out  NUM_SRC*DATA_W  forwarded operand

Behaviour:
- State: per slot valid, we, dst, load. Reset (async): all slots invalid, so all outputs are 0.
- Match: slot s matches source k when valid & we & dst==addr_k & addr_k!=0 & src_use_k.
- Youngest match (lowest s) wins. If it is ready (non-load, or load with s>=LOAD_RDY_SLOT): fwd_en_k=1, fwd_data_k=stg_data_i[s]. Not ready: fwd_en_k=0 and request a hazard stall.
- No match: fwd_en_k=0, fwd_data_k=0.
- Register 0 is never forwarded and never stalls.
- stall_o = hazard_stall & ~flush_i. It is combinational: same-cycle from inputs and state, zero latency.
- Slot update per posedge, in priority order:
  1. ext_stall_i: all slots hold. Flush and issue are ignored; the datapath keeps flush_i asserted until the freeze lifts.
  2. flush_i: slot0 <= bubble; slot s <= slot s-1 for s>=1. The old slot0 still drains, because flush removes only D and E's successor; E itself is already squashed by the datapath.
  3. hazard stall: slot0 <= bubble; higher slots shift.
  4. normal: slot0 <= {iss_valid_i, iss_we_i, iss_dst_i, iss_load_i}; higher slots shift.
- Slot NUM_STG-1 is discarded on shift. The register file write occurs that cycle; same-cycle W-to-D write-through is the register file's job, and slot NUM_STG-1 forwarding covers it.
- Reset mid-operation clears the scoreboard immediately. stall_o deasserts asynchronously.

Optional Feature:
HAZARD_PERF_EN: adds outputs perf_stall_cnt_o[31:0] and perf_fwd_cnt_o[31:0].
- perf_stall_cnt_o increments on each cycle with stall_o=1 & ~ext_stall_i.
- perf_fwd_cnt_o adds popcount(fwd_en_o) per non-frozen cycle.
- Both counters wrap at 2^32 and reset to 0.
- Without the macro, the ports and counters are absent. Functional behaviour is identical either way.

Decomposition:
- Package hazard_pkg:
  - typedef hz_slot_t {valid, we, dst[REG_AW], load}
  - localparam REG_ZERO = 0
  - function is_ready(slot, idx)
- Sub-module hazard_src_match: one instance per source. Takes the scoreboard and one address; outputs fwd_en, selected slot index, and not-ready flag. Generated NUM_SRC times.

Test Plan:
- Back-to-back ALU RAW: issue dst=8 (non-load), next cycle src_addr0=8 use=1, stg_data_i[0]=0x1234 -> fwd_en_o[0]=1, fwd_data_o[0]=0x1234, stall_o=0.
- Load-use: issue load dst=9, next cycle src1=9 -> stall_o=1 for exactly one cycle. Then the load is in slot1 and fwd_data_o[1]=stg_data_i[1]=0xCAFE, stall_o=0.
- Priority: dst=5 in slot2 (0x2) and dst=5 in slot0 (0x1), src0=5 -> fwd_data_o[0]=0x1. Same case with the slot0 entry a load -> stall_o=1, fwd_en_o[0]=0.
- Zero register: issue dst=0 we=1, then src0=0 -> fwd_en_o=0, stall_o=0.
- Flush: load dst=9 in slot0, flush_i=1 with src0=9 -> stall_o=0. Next cycle slot0 is a bubble and the issue is ignored.
- Freeze/reset: ext_stall_i=1 for 3 cycles with dst=7 in slot0 -> match persists at slot0 throughout. Assert rst asynchronously mid-cycle -> fwd_en_o=0 and stall_o=0 before the next edge.
